// File: rtl/div_pkg.sv
// Shared definitions for the divider request sequencer: FSM states, default width and
// field positions within the packed divider values/result buses.
package div_pkg;

    localparam int unsigned HALF_W_DEF = 8;

    // values = {dividend, divisor}, result = {quotient, remainder}: upper half is field 1
    localparam int unsigned FIELD_HI = 1;
    localparam int unsigned FIELD_LO = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } div_state_t;

endpackage

// File: rtl/div_op_fifo.sv
// Synchronous operand FIFO holding packed {dividend, divisor} pairs; registered count
// drives full/empty so the upstream ready never depends on a same-cycle pop.
module div_op_fifo
    import div_pkg::*;
#(
    parameter int unsigned W     = 2 * HALF_W_DEF,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic [W-1:0] wr_data,
    input  logic         pop,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/div_req_sequencer.sv
// Buffers operand pairs and issues them one at a time to the divider, with ack watchdog.
// Optional DIV_ZERO_CHECK_EN: divisor==0 is answered locally with an error, no div_req.
module div_req_sequencer
    import div_pkg::*;
#(
    parameter int unsigned HALF_W      = HALF_W_DEF,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [HALF_W-1:0]   in_dividend,
    input  logic [HALF_W-1:0]   in_divisor,
    output logic                div_req,
    output logic [2*HALF_W-1:0] div_values,
    input  logic                div_ack,
    input  logic [2*HALF_W-1:0] div_result,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [HALF_W-1:0]   out_quotient,
    output logic [HALF_W-1:0]   out_remainder,
    output logic                out_err,
    output logic                busy
);

    localparam int unsigned W2 = 2 * HALF_W;
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);

    div_state_t      state;
    div_state_t      state_nxt;
    logic [W2-1:0]   op_reg;
    logic [TW-1:0]   timer;
    logic [HALF_W-1:0] q_reg;
    logic [HALF_W-1:0] r_reg;
    logic            err_reg;

    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_pop;
    logic [W2-1:0]   fifo_rd_data;

    logic            res_load;
    logic [HALF_W-1:0] res_q;
    logic [HALF_W-1:0] res_r;
    logic            res_err;

    div_op_fifo #(
        .W     (W2),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (in_valid),
        .wr_data ({in_dividend, in_divisor}),
        .pop     (fifo_pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        state_nxt = state;
        fifo_pop  = 1'b0;
        res_load  = 1'b0;
        res_q     = '0;
        res_r     = '0;
        res_err   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    state_nxt = ST_ISSUE;
`ifdef DIV_ZERO_CHECK_EN
                    if (fifo_rd_data[FIELD_LO*HALF_W +: HALF_W] == '0) begin
                        state_nxt = ST_HOLD;
                        res_load  = 1'b1;
                        res_q     = '1;
                        res_r     = fifo_rd_data[FIELD_HI*HALF_W +: HALF_W];
                        res_err   = 1'b1;
                    end
`endif
                end
            end
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (div_ack) begin
                    state_nxt = ST_HOLD;
                    res_load  = 1'b1;
                    res_q     = div_result[FIELD_HI*HALF_W +: HALF_W];
                    res_r     = div_result[FIELD_LO*HALF_W +: HALF_W];
                end else if (timer == TIMER_LAST) begin
                    state_nxt = ST_HOLD;
                    res_load  = 1'b1;
                    res_err   = 1'b1;
                end
            end
            ST_HOLD: begin
                if (out_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            op_reg  <= '0;
            timer   <= '0;
            q_reg   <= '0;
            r_reg   <= '0;
            err_reg <= 1'b0;
        end else begin
            state <= state_nxt;
            if (fifo_pop) op_reg <= fifo_rd_data;
            // timer reads 0 on the first WAIT cycle, so WAIT lasts exactly TIMEOUT_CYC cycles
            if (state == ST_ISSUE)     timer <= '0;
            else if (state == ST_WAIT) timer <= timer + TW'(1);
            if (res_load) begin
                q_reg   <= res_q;
                r_reg   <= res_r;
                err_reg <= res_err;
            end
        end
    end

    assign in_ready      = !fifo_full;
    assign div_req       = (state == ST_ISSUE);
    assign div_values    = (state == ST_ISSUE || state == ST_WAIT) ? op_reg : '0;
    assign out_valid     = (state == ST_HOLD);
    assign out_quotient  = q_reg;
    assign out_remainder = r_reg;
    assign out_err       = err_reg;
    assign busy          = (state != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_div_req_sequencer.sv
// Directed bench for div_req_sequencer with a behavioural divider answering each request.
module tb_div_req_sequencer;

    localparam int TIMEOUT = 64;
    localparam int LAT     = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_dividend;
    logic [7:0]  in_divisor;
    logic        div_req;
    logic [15:0] div_values;
    logic        div_ack;
    logic [15:0] div_result;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_quotient;
    logic [7:0]  out_remainder;
    logic        out_err;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    div_req_sequencer #(
        .HALF_W      (8),
        .FIFO_DEPTH  (4),
        .TIMEOUT_CYC (TIMEOUT)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_dividend   (in_dividend),
        .in_divisor    (in_divisor),
        .div_req       (div_req),
        .div_values    (div_values),
        .div_ack       (div_ack),
        .div_result    (div_result),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_quotient  (out_quotient),
        .out_remainder (out_remainder),
        .out_err       (out_err),
        .busy          (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural divider: answers LAT+1 cycles after seeing a request, when enabled
    logic        ack_en;
    logic        force_ack;
    logic        model_ack;
    logic        pend;
    int          cnt;
    int          req_count;
    logic [15:0] lat_vals;

    assign div_ack = model_ack | force_ack;

    always @(posedge clk) begin
        if (!reset_n) begin
            pend       <= 1'b0;
            cnt        <= 0;
            model_ack  <= 1'b0;
            div_result <= '0;
        end else begin
            model_ack <= 1'b0;
            if (div_req) begin
                check("req_overlap", 32'(pend), 0);
                req_count <= req_count + 1;
                if (ack_en) begin
                    pend     <= 1'b1;
                    cnt      <= LAT;
                    lat_vals <= div_values;
                end
            end else if (pend) begin
                if (cnt == 0) begin
                    model_ack  <= 1'b1;
                    pend       <= 1'b0;
                    div_result <= (lat_vals[7:0] == 8'd0) ? {8'hFF, lat_vals[15:8]}
                                : {lat_vals[15:8] / lat_vals[7:0], lat_vals[15:8] % lat_vals[7:0]};
                end else begin
                    cnt <= cnt - 1;
                end
            end
        end
    end

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
    } vec_t;

    vec_t vecs [8];

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        force_ack = 1'b0;
        reset_n   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Drives one cycle of in_valid starting at a negedge; ok reports whether it was taken
    task automatic push(input logic [7:0] a, input logic [7:0] b, output bit ok);
        in_valid    = 1'b1;
        in_dividend = a;
        in_divisor  = b;
        ok          = in_ready;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic get_result(input string name, input logic [7:0] q, input logic [7:0] r,
                              input logic err);
        int n = 0;
        while (!out_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            check({name, "_timeout"}, 0, 1);
        end else begin
            check({name, "_q"}, 32'(out_quotient), 32'(q));
            check({name, "_r"}, 32'(out_remainder), 32'(r));
            check({name, "_err"}, 32'(out_err), 32'(err));
            out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            out_ready = 1'b0;
        end
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (!div_req && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({name, "_req_seen"}, 32'(div_req), 1);
    endtask

    initial begin
        bit ok;
        int accepted;
        int n;
        int rc;

        vecs[0] = '{8'd100, 8'd7,  8'd14,  8'd2};
        vecs[1] = '{8'd200, 8'd13, 8'd15,  8'd5};
        vecs[2] = '{8'd255, 8'd1,  8'd255, 8'd0};
        vecs[3] = '{8'd9,   8'd10, 8'd0,   8'd9};
        vecs[4] = '{8'd50,  8'd5,  8'd10,  8'd0};
        vecs[5] = '{8'd77,  8'd8,  8'd9,   8'd5};
        vecs[6] = '{8'd128, 8'd16, 8'd8,   8'd0};
        vecs[7] = '{8'd42,  8'd0,  8'hFF,  8'd42};

        ack_en      = 1'b1;
        req_count   = 0;
        in_dividend = '0;
        in_divisor  = '0;
        do_reset();

        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_div_req", 32'(div_req), 0);
        check("rst_div_values", 32'(div_values), 0);
        check("rst_err", 32'(out_err), 0);
        check("rst_q", 32'(out_quotient), 0);

        // Test 1: single op timing
        rc = req_count;
        push(vecs[0].a, vecs[0].b, ok);
        check("t1_accept", 32'(ok), 1);
        check("t1_req_idle", 32'(div_req), 0);
        check("t1_busy", 32'(busy), 1);
        @(negedge clk);
        check("t1_req_issue", 32'(div_req), 1);
        check("t1_values_issue", 32'(div_values), 32'h6407);
        @(negedge clk);
        check("t1_req_wait", 32'(div_req), 0);
        check("t1_values_wait", 32'(div_values), 32'h6407);
        get_result("t1", vecs[0].q, vecs[0].r, 1'b0);
        check("t1_req_count", 32'(req_count - rc), 1);
        check("t1_values_after", 32'(div_values), 0);

        // Table sweep: each vector pushed and collected in turn
        for (int i = 0; i < 7; i++) begin
            push(vecs[i].a, vecs[i].b, ok);
            check($sformatf("vec%0d_accept", i), 32'(ok), 1);
            get_result($sformatf("vec%0d", i), vecs[i].q, vecs[i].r, 1'b0);
        end

        // Test 2: back-to-back pushes, results in order
        for (int i = 1; i <= 3; i++) push(vecs[i].a, vecs[i].b, ok);
        for (int i = 1; i <= 3; i++) get_result($sformatf("t2_%0d", i), vecs[i].q, vecs[i].r, 1'b0);

        // Test 3: consumer stalled, 7 offered, 5 accepted
        accepted = 0;
        for (int i = 0; i < 7; i++) begin
            push(vecs[i].a, vecs[i].b, ok);
            if (ok) accepted++;
        end
        repeat (20) @(negedge clk);
        check("t3_accepted", 32'(accepted), 5);
        check("t3_in_ready", 32'(in_ready), 0);
        check("t3_out_valid", 32'(out_valid), 1);
        check("t3_hold_q", 32'(out_quotient), 32'(vecs[0].q));
        for (int i = 0; i < 5; i++) get_result($sformatf("t3_%0d", i), vecs[i].q, vecs[i].r, 1'b0);
        check("t3_idle_busy", 32'(busy), 0);

        // Test 4: no ack, watchdog fires TIMEOUT cycles after WAIT entry
        ack_en = 1'b0;
        push(8'd10, 8'd3, ok);
        wait_req("t4");
        @(posedge clk);
        n = 0;
        forever begin
            @(negedge clk);
            if (out_valid || n >= 200) break;
            @(posedge clk);
            n++;
        end
        check("t4_timeout_cycles", 32'(n), 32'(TIMEOUT));
        check("t4_q", 32'(out_quotient), 0);
        check("t4_r", 32'(out_remainder), 0);
        check("t4_err", 32'(out_err), 1);
        force_ack = 1'b1;
        @(negedge clk);
        force_ack = 1'b0;
        check("t4_hold_err", 32'(out_err), 1);
        check("t4_hold_q", 32'(out_quotient), 0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        force_ack = 1'b1;
        @(negedge clk);
        force_ack = 1'b0;
        @(negedge clk);
        check("t4_late_ack_valid", 32'(out_valid), 0);
        check("t4_late_ack_busy", 32'(busy), 0);
        ack_en = 1'b1;
        do_reset();

        // Test 5: divide by zero
        rc = req_count;
        push(vecs[7].a, vecs[7].b, ok);
`ifdef DIV_ZERO_CHECK_EN
        get_result("t5", vecs[7].q, vecs[7].r, 1'b1);
        check("t5_req_count", 32'(req_count - rc), 0);
`else
        get_result("t5", vecs[7].q, vecs[7].r, 1'b0);
        check("t5_req_count", 32'(req_count - rc), 1);
`endif
        do_reset();

        // Test 6: reset while waiting for ack
        push(8'd60, 8'd6, ok);
        wait_req("t6");
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("t6_out_valid", 32'(out_valid), 0);
        check("t6_in_ready", 32'(in_ready), 1);
        check("t6_busy", 32'(busy), 0);
        check("t6_div_req", 32'(div_req), 0);
        reset_n = 1'b1;
        @(negedge clk);
        push(vecs[4].a, vecs[4].b, ok);
        get_result("t6", vecs[4].q, vecs[4].r, 1'b0);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
